phys_free_list_ctrl: RTL and testbench

//  Owns the physical-register free list used by RENAME in the out-of-order MIPS core.

---
 rtl/phys_free_list_ctrl_pkg.sv | 8 +
 rtl/phys_free_list_ctrl_ram.sv | 16 +
 rtl/phys_free_list_ctrl.sv | 80 ++++++++
 tb/tb_phys_free_list_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/phys_free_list_ctrl_pkg.sv
// phys_free_list_ctrl_pkg: free-list sizing, pointer type and FSM state encodings
package phys_free_list_ctrl_pkg;
    localparam int LOG_PHYS = 6;
    localparam int NUM_PHYS = 1 << LOG_PHYS;
    localparam int NUM_ARCH = 32;
    typedef enum logic [1:0] {FL_INIT, FL_RUN, FL_RECOVER} fl_state_t;
    typedef logic [LOG_PHYS:0] ptr_t;
endpackage

// File: rtl/phys_free_list_ctrl_ram.sv
// phys_free_list_ctrl_ram: free-list storage, async read, sync write
module phys_free_list_ctrl_ram
    import phys_free_list_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                we,
    input  logic [LOG_PHYS-1:0] waddr,
    input  logic [LOG_PHYS-1:0] wdata,
    input  logic [LOG_PHYS-1:0] raddr,
    output logic [LOG_PHYS-1:0] rdata
);
    logic [LOG_PHYS-1:0] mem [NUM_PHYS];
    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/phys_free_list_ctrl.sv
// phys_free_list_ctrl: rename free list with speculative/committed heads and flush rollback
module phys_free_list_ctrl
    import phys_free_list_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                Alloc_IN,
    input  logic                Commit_alloc_IN,
    input  logic                Release_valid_IN,
    input  logic [LOG_PHYS-1:0] Release_reg_IN,
    input  logic                Flush_IN,
    output logic [LOG_PHYS-1:0] Free_phys_reg,
    output logic                Free_reg_avail,
    output logic [LOG_PHYS:0]   Free_count,
    output logic                Ready,
    output logic                Underflow_ERR,
    output logic                Overflow_ERR
);
    fl_state_t           state, state_nxt;
    logic [LOG_PHYS-1:0] init_cnt;
    ptr_t                spec_head, commit_head, tail;
    logic                run, flush, alloc_ok, commit_ok, rel_ok, full, init_done;
    logic                we;
    logic [LOG_PHYS-1:0] waddr, wdata;

    assign run            = state == FL_RUN;
    assign Ready          = state != FL_INIT;
    assign Free_count     = tail - spec_head;
    assign Free_reg_avail = run && Free_count != '0;
    assign flush          = run && Flush_IN;
    assign alloc_ok       = Alloc_IN && Free_reg_avail && !Flush_IN;
    assign commit_ok      = run && Commit_alloc_IN && (commit_head != spec_head || alloc_ok);
    assign full           = (tail - commit_head) == ptr_t'(NUM_PHYS);
    assign rel_ok         = Ready && Release_valid_IN && !full;
    assign init_done      = init_cnt == LOG_PHYS'(NUM_PHYS - NUM_ARCH - 1);

    // INIT seeds the non-architectural regs through the release write port
    assign we    = !Ready || rel_ok;
    assign waddr = Ready ? tail[LOG_PHYS-1:0] : init_cnt;
    assign wdata = Ready ? Release_reg_IN : LOG_PHYS'(NUM_ARCH) + init_cnt;

    always_comb begin
        state_nxt = state == FL_INIT ? (init_done ? FL_RUN : FL_INIT) : (flush ? FL_RECOVER : FL_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= FL_INIT;
            init_cnt      <= '0;
            spec_head     <= '0;
            commit_head   <= '0;
            tail          <= '0;
            Underflow_ERR <= 1'b0;
            Overflow_ERR  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FL_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_done) tail <= ptr_t'(NUM_PHYS - NUM_ARCH);
            end else begin
                if (rel_ok) tail <= tail + 1'b1;
                if (commit_ok) commit_head <= commit_head + 1'b1;
                // rollback target includes a commit retiring in the flush cycle
                spec_head <= flush ? commit_head + ptr_t'(commit_ok) : spec_head + ptr_t'(alloc_ok);
                if (run && ((Alloc_IN && !Free_reg_avail && !Flush_IN) || (Commit_alloc_IN && !commit_ok)))
                    Underflow_ERR <= 1'b1;
                if (Release_valid_IN && full) Overflow_ERR <= 1'b1;
            end
        end
    end

    phys_free_list_ctrl_ram u_ram (
        .CLK   (CLK),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (spec_head[LOG_PHYS-1:0]),
        .rdata (Free_phys_reg)
    );
endmodule

// File: tb/tb_phys_free_list_ctrl.sv
// tb_phys_free_list_ctrl: directed stimulus with queued expectations checked by a monitor
module tb_phys_free_list_ctrl;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       Alloc_IN, Commit_alloc_IN, Release_valid_IN, Flush_IN;
    logic [5:0] Release_reg_IN;
    logic [5:0] Free_phys_reg;
    logic       Free_reg_avail;
    logic [6:0] Free_count;
    logic       Ready, Underflow_ERR, Overflow_ERR;

    typedef struct {
        string      name;
        logic       rdy;
        logic       av;
        logic       chk_r;
        logic [5:0] r;
        logic [6:0] cnt;
        logic       uf;
        logic       of;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    phys_free_list_ctrl dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .Alloc_IN         (Alloc_IN),
        .Commit_alloc_IN  (Commit_alloc_IN),
        .Release_valid_IN (Release_valid_IN),
        .Release_reg_IN   (Release_reg_IN),
        .Flush_IN         (Flush_IN),
        .Free_phys_reg    (Free_phys_reg),
        .Free_reg_avail   (Free_reg_avail),
        .Free_count       (Free_count),
        .Ready            (Ready),
        .Underflow_ERR    (Underflow_ERR),
        .Overflow_ERR     (Overflow_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input logic a, input logic c, input logic rv, input logic [5:0] rr, input logic f);
        Alloc_IN         = a;
        Commit_alloc_IN  = c;
        Release_valid_IN = rv;
        Release_reg_IN   = rr;
        Flush_IN         = f;
    endtask

    task automatic expect_after(input string n, input logic rdy, input logic av, input logic chk_r,
                                input logic [5:0] r, input logic [6:0] cnt, input logic uf, input logic of);
        exp_t e;
        e.name = n; e.rdy = rdy; e.av = av; e.chk_r = chk_r; e.r = r; e.cnt = cnt; e.uf = uf; e.of = of;
        q.push_back(e);
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    task automatic init_seq(input string tag);
        for (int k = 1; k < 32; k++) begin
            expect_after({tag, "_busy"}, 1'b0, 1'b0, 1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
            tick;
        end
        expect_after({tag, "_ready"}, 1'b1, 1'b1, 1'b1, 6'd32, 7'd32, 1'b0, 1'b0);
        tick;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (Ready !== e.rdy || Free_reg_avail !== e.av || (e.chk_r && Free_phys_reg !== e.r) ||
                    Free_count !== e.cnt || Underflow_ERR !== e.uf || Overflow_ERR !== e.of) begin
                    bad++;
                    $display("FAIL %s: got rdy=%b av=%b reg=%0d cnt=%0d uf=%b of=%b, want rdy=%b av=%b reg=%0d(chk=%b) cnt=%0d uf=%b of=%b",
                             e.name, Ready, Free_reg_avail, Free_phys_reg, Free_count, Underflow_ERR, Overflow_ERR,
                             e.rdy, e.av, e.r, e.chk_r, e.cnt, e.uf, e.of);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 6'd0, 0);
        tick;
        tick;
        expect_after("reset", 1'b0, 1'b0, 1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
        tick;
        RESET = 1'b0;
        init_seq("init");
        drive(1, 0, 0, 6'd0, 0);
        expect_after("alloc1", 1'b1, 1'b1, 1'b1, 6'd33, 7'd31, 1'b0, 1'b0);
        tick;
        expect_after("alloc2", 1'b1, 1'b1, 1'b1, 6'd34, 7'd30, 1'b0, 1'b0);
        tick;
        expect_after("alloc3", 1'b1, 1'b1, 1'b1, 6'd35, 7'd29, 1'b0, 1'b0);
        tick;
        expect_after("alloc4", 1'b1, 1'b1, 1'b1, 6'd36, 7'd28, 1'b0, 1'b0);
        tick;
        drive(0, 1, 0, 6'd0, 0);
        expect_after("commit1", 1'b1, 1'b1, 1'b1, 6'd36, 7'd28, 1'b0, 1'b0);
        tick;
        drive(0, 0, 0, 6'd0, 1);
        expect_after("flush", 1'b1, 1'b0, 1'b1, 6'd33, 7'd31, 1'b0, 1'b0);
        tick;
        drive(1, 0, 0, 6'd0, 0);
        expect_after("recover_alloc", 1'b1, 1'b1, 1'b1, 6'd33, 7'd31, 1'b0, 1'b0);
        tick;
        for (int i = 1; i <= 31; i++) begin
            if (i == 31) expect_after("drain", 1'b1, 1'b0, 1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
            tick;
        end
        expect_after("alloc_empty", 1'b1, 1'b0, 1'b0, 6'd0, 7'd0, 1'b1, 1'b0);
        tick;
        drive(0, 0, 1, 6'd5, 0);
        expect_after("release5", 1'b1, 1'b1, 1'b1, 6'd5, 7'd1, 1'b1, 1'b0);
        tick;
        drive(1, 0, 1, 6'd7, 0);
        expect_after("alloc_rel7", 1'b1, 1'b1, 1'b1, 6'd7, 7'd1, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < 31; i++) begin
            drive(0, 0, 1, 6'(i), 0);
            if (i == 30) expect_after("fill", 1'b1, 1'b1, 1'b1, 6'd7, 7'd32, 1'b1, 1'b0);
            tick;
        end
        drive(0, 0, 1, 6'd9, 0);
        expect_after("overflow", 1'b1, 1'b1, 1'b1, 6'd7, 7'd32, 1'b1, 1'b1);
        tick;
        drive(0, 0, 0, 6'd0, 1);
        expect_after("flush_full", 1'b1, 1'b0, 1'b1, 6'd33, 7'd64, 1'b1, 1'b1);
        tick;
        RESET = 1'b1;
        drive(0, 0, 0, 6'd0, 0);
        expect_after("reset_recover", 1'b0, 1'b0, 1'b0, 6'd0, 7'd0, 1'b0, 1'b0);
        tick;
        RESET = 1'b0;
        init_seq("reinit");
        drive(0, 1, 0, 6'd0, 0);
        expect_after("commit_empty", 1'b1, 1'b1, 1'b1, 6'd32, 7'd32, 1'b1, 1'b0);
        tick;
        drive(1, 1, 0, 6'd0, 0);
        expect_after("alloc_commit", 1'b1, 1'b1, 1'b1, 6'd33, 7'd31, 1'b1, 1'b0);
        tick;
        drive(1, 0, 0, 6'd0, 0);
        expect_after("alloc5", 1'b1, 1'b1, 1'b1, 6'd34, 7'd30, 1'b1, 1'b0);
        tick;
        drive(1, 1, 0, 6'd0, 1);
        expect_after("flush_commit", 1'b1, 1'b0, 1'b1, 6'd34, 7'd30, 1'b1, 1'b0);
        tick;
        drive(0, 0, 0, 6'd0, 0);
        expect_after("recover_exit", 1'b1, 1'b1, 1'b1, 6'd34, 7'd30, 1'b1, 1'b0);
        tick;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
